// File: rtl/multiword_add_ctrl_if.sv
// Request/response bundle for the word-serial multi-word adder.
// master = requester + consumer side, slave = the adder controller.
interface multiword_add_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned N = WIDTH * WORDS;

  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         carry_in;
  logic         sub;
  logic [N-1:0] result;
  logic         carry_out;
  logic         done_valid;
  logic         done_ready;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, carry_in, sub, done_ready,
    input  start_ready, result, carry_out, done_valid, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, carry_in, sub, done_ready,
    output start_ready, result, carry_out, done_valid, busy
  );
endinterface

// File: rtl/multiword_add_ctrl.sv
// Word-serial add/subtract of WORDS*WIDTH-bit operands through one WIDTH-bit adder slice,
// LS word first, with a registered inter-word carry.
module multiword_add_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multiword_add_ctrl_if.slave  bus
);
  localparam int unsigned N     = WIDTH * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N-1:0]       result_q;
  logic               carry_out_q;

  logic [WIDTH-1:0]   a_word;
  logic [WIDTH-1:0]   b_word;
  logic [WIDTH-1:0]   sum_word;
  logic               slice_cout;
  logic               last_word;

  // Adder slice: current word of each operand plus the registered carry.
  always_comb begin
    a_word = a_q[WIDTH * 32'(idx_q) +: WIDTH];
    b_word = b_q[WIDTH * 32'(idx_q) +: WIDTH];
    {slice_cout, sum_word} = {1'b0, a_word} + {1'b0, b_word} + (WIDTH + 1)'(carry_q);
    last_word = (idx_q == IDX_W'(WORDS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
            a_q      <= bus.op_a;
            b_q      <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q  <= bus.sub ? 1'b1 : bus.carry_in;
            idx_q    <= '0;
            result_q <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q[WIDTH * 32'(idx_q) +: WIDTH] <= sum_word;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_word) begin
            carry_out_q <= slice_cout;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.done_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result      = result_q;
  assign bus.carry_out   = carry_out_q;
  assign bus.done_valid  = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.start_ready = (state_q == IDLE) && !rst;
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed and randomized checks of multiword_add_ctrl against an N+1-bit arithmetic model.
module tb_multiword_add_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = WIDTH * WORDS;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multiword_add_ctrl_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

  multiword_add_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {carry_out, result}. Subtract carry is "no borrow", i.e. a >= b.
  function automatic logic [N:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic cin, input logic s);
    logic [N-1:0] diff;
    if (s) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b} + (N + 1)'(cin);
  endfunction

  // One full transaction; stall = cycles done_ready is held low once done_valid rises.
  task automatic run_txn(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input logic s, input int stall);
    logic [N:0] exp;
    int         n;
    exp = ref_model(a, b, cin, s);
    n = 0;
    while (!bus.start_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "/start_ready"}, 64'(bus.start_ready), 64'(1));
    bus.start_valid = 1'b1;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.carry_in    = cin;
    bus.sub         = s;
    bus.done_ready  = (stall == 0);
    step();
    // Operands may change freely after acceptance.
    bus.start_valid = 1'b0;
    bus.op_a        = $urandom;
    bus.op_b        = $urandom;
    bus.carry_in    = 1'($urandom_range(0, 1));
    bus.sub         = 1'($urandom_range(0, 1));
    check({tag, "/busy"}, 64'(bus.busy), 64'(1));
    n = 0;
    while (!bus.done_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'(WORDS));
    check({tag, "/result"}, 64'(bus.result), 64'(exp[N-1:0]));
    check({tag, "/carry_out"}, 64'(bus.carry_out), 64'(exp[N]));
    for (int i = 0; i < stall; i++) begin
      bus.start_valid = 1'(i % 2);
      step();
      check({tag, "/stall_done_valid"}, 64'(bus.done_valid), 64'(1));
      check({tag, "/stall_result"}, 64'(bus.result), 64'(exp[N-1:0]));
      check({tag, "/stall_start_ready"}, 64'(bus.start_ready), 64'(0));
    end
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b1;
    step();
    check({tag, "/done_valid_fall"}, 64'(bus.done_valid), 64'(0));
    check({tag, "/idle_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "/idle_start_ready"}, 64'(bus.start_ready), 64'(1));
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rs;
    logic         rc;
    int           st;

    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.carry_in    = 1'b0;
    bus.sub         = 1'b0;
    bus.done_ready  = 1'b0;
    step();
    step();
    check("reset/result", 64'(bus.result), 64'(0));
    check("reset/carry_out", 64'(bus.carry_out), 64'(0));
    check("reset/done_valid", 64'(bus.done_valid), 64'(0));
    check("reset/busy", 64'(bus.busy), 64'(0));
    check("reset/start_ready_in_rst", 64'(bus.start_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("reset/start_ready_after", 64'(bus.start_ready), 64'(1));

    run_txn("t1_add_carry8", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    check("t1/result_abs", 64'(bus.result), 64'(32'h0000_0100));
    run_txn("t2_full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    check("t2/result_abs", 64'(bus.result), 64'(0));
    check("t2/carry_abs", 64'(bus.carry_out), 64'(1));
    run_txn("t3_sub_borrow", 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 0);
    check("t3a/result_abs", 64'(bus.result), 64'(32'hFFFF_FFF0));
    check("t3a/carry_abs", 64'(bus.carry_out), 64'(0));
    run_txn("t3_sub_noborrow", 32'h0000_0020, 32'h0000_0010, 1'b0, 1'b1, 0);
    check("t3b/result_abs", 64'(bus.result), 64'(32'h0000_0010));
    check("t3b/carry_abs", 64'(bus.carry_out), 64'(1));
    run_txn("t4_stall5", 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0, 5);

    // Abort mid-RUN at idx=2.
    bus.start_valid = 1'b1;
    bus.op_a        = 32'h00FF_FFFF;
    bus.op_b        = 32'h0000_0001;
    bus.carry_in    = 1'b0;
    bus.sub         = 1'b0;
    bus.done_ready  = 1'b1;
    step();
    bus.start_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("t5/abort_busy", 64'(bus.busy), 64'(0));
    check("t5/abort_done_valid", 64'(bus.done_valid), 64'(0));
    check("t5/abort_result", 64'(bus.result), 64'(0));
    check("t5/abort_carry_out", 64'(bus.carry_out), 64'(0));
    check("t5/abort_start_ready_in_rst", 64'(bus.start_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("t5/start_ready_after", 64'(bus.start_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5/no_done_after_abort", 64'(bus.done_valid), 64'(0));
    end
    run_txn("t5_after_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);
    check("t5/result_abs", 64'(bus.result), 64'(32'h2345_6789));

    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 1) ? '1 : '0;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
      run_txn("rand", ra, rb, rc, rs, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
